// File: rtl/signed_mul_arbiter.sv
// Round-robin front end that serializes N_REQ clients onto one W-bit signed multiplier.
// The result (truncated product, overflow flag, owner ID) leaves through a valid/ready handshake.
module signed_mul_arbiter #(
    parameter int unsigned N_REQ = 4,
    parameter int unsigned W     = 4,
    parameter int unsigned IDW   = 2
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [N_REQ-1:0]   req,
    input  logic [N_REQ*W-1:0] op_a,
    input  logic [N_REQ*W-1:0] op_b,
    output logic [N_REQ-1:0]   grant,
    output logic               busy,
    output logic               res_valid,
    input  logic               res_ready,
    output logic [IDW-1:0]     res_id,
    output logic [W-1:0]       res_prod,
    output logic               res_overflow
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MUL  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t               r_state;
    state_t               w_next;
    logic [IDW-1:0]       r_rr_ptr;
    logic [W-1:0]         r_a;
    logic [W-1:0]         r_b;
    logic [IDW-1:0]       r_cap_id;
    logic                 r_valid;
    logic [IDW-1:0]       r_res_id;
    logic [W-1:0]         r_res_prod;
    logic                 r_res_ovf;

    logic                 w_found;
    logic [IDW-1:0]       w_idx;
    logic [N_REQ-1:0]     w_oh;
    logic [W-1:0]         w_sel_a;
    logic [W-1:0]         w_sel_b;
    logic [31:0]          w_j;
    logic signed [2*W-1:0] w_prod;
    logic [W:0]           w_top;
    logic                 w_ovf;

    // Circular search starting at r_rr_ptr; first set request wins.
    always_comb begin
        w_found = 1'b0;
        w_idx   = '0;
        w_oh    = '0;
        w_sel_a = '0;
        w_sel_b = '0;
        w_j     = '0;
        for (int unsigned k = 0; k < N_REQ; k++) begin
            w_j = (32'(r_rr_ptr) + k) % N_REQ;
            if (!w_found && req[w_j]) begin
                w_found    = 1'b1;
                w_idx      = IDW'(w_j);
                w_oh[w_j]  = 1'b1;
                w_sel_a    = op_a[w_j*W +: W];
                w_sel_b    = op_b[w_j*W +: W];
            end
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE:    if (w_found) w_next = MUL;
            MUL:     w_next = DONE;
            DONE:    if (res_ready) w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    assign w_prod = $signed({{W{r_a[W-1]}}, r_a}) * $signed({{W{r_b[W-1]}}, r_b});
    assign w_top  = w_prod[2*W-1:W-1];
    // Product fits in W bits only when the upper W+1 bits are a pure sign extension.
    assign w_ovf  = !((&w_top) || !(|w_top));

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= IDLE;
            r_rr_ptr   <= '0;
            r_a        <= '0;
            r_b        <= '0;
            r_cap_id   <= '0;
            r_valid    <= 1'b0;
            r_res_id   <= '0;
            r_res_prod <= '0;
            r_res_ovf  <= 1'b0;
        end else begin
            r_state <= w_next;
            case (r_state)
                IDLE: begin
                    if (w_found) begin
                        r_a      <= w_sel_a;
                        r_b      <= w_sel_b;
                        r_cap_id <= w_idx;
                        if (w_idx == IDW'(N_REQ - 1)) r_rr_ptr <= '0;
                        else                          r_rr_ptr <= w_idx + 1'b1;
                    end
                end
                MUL: begin
                    r_res_prod <= w_prod[W-1:0];
                    r_res_ovf  <= w_ovf;
                    r_res_id   <= r_cap_id;
                    r_valid    <= 1'b1;
                end
                DONE: begin
                    if (res_ready) r_valid <= 1'b0;
                end
                default: r_valid <= 1'b0;
            endcase
        end
    end

    assign grant        = (r_state == IDLE && !rst) ? w_oh : '0;
    assign busy         = (r_state == MUL) || (r_state == DONE);
    assign res_valid    = r_valid;
    assign res_id       = r_res_id;
    assign res_prod     = r_res_prod;
    assign res_overflow = r_res_ovf;

endmodule

// File: tb/tb_signed_mul_arbiter.sv
// Directed bench for signed_mul_arbiter: arbitration order, product/overflow values,
// handshake timing, backpressure and mid-operation reset.
module tb_signed_mul_arbiter;

    logic        clk;
    logic        rst;
    logic [3:0]  req;
    logic [15:0] op_a;
    logic [15:0] op_b;
    logic [3:0]  grant;
    logic        busy;
    logic        res_valid;
    logic        res_ready;
    logic [1:0]  res_id;
    logic [3:0]  res_prod;
    logic        res_overflow;

    int n_pass  = 0;
    int n_total = 0;

    signed_mul_arbiter #(.N_REQ(4), .W(4), .IDW(2)) dut (
        .clk          (clk),
        .rst          (rst),
        .req          (req),
        .op_a         (op_a),
        .op_b         (op_b),
        .grant        (grant),
        .busy         (busy),
        .res_valid    (res_valid),
        .res_ready    (res_ready),
        .res_id       (res_id),
        .res_prod     (res_prod),
        .res_overflow (res_overflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: observed timeout required finish");
        $fatal(1, "watchdog expired");
    end

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0h required %0h", tag, obs, exp);
    endtask

    // One full transaction on lane idx with res_ready high; expected values supplied by caller.
    task automatic run_one(input int idx, input logic [3:0] a, input logic [3:0] b,
                           input logic [3:0] exp_grant, input logic [3:0] exp_prod,
                           input logic exp_ovf);
        req             = exp_grant;
        op_a[idx*4 +: 4] = a;
        op_b[idx*4 +: 4] = b;
        res_ready       = 1'b1;
        #1;
        chk("one_grant", 32'(grant), 32'(exp_grant));
        tick();
        req = 4'b0000;
        #1;
        chk("one_mul", {busy, res_valid, grant}, {1'b1, 1'b0, 4'b0000});
        tick();
        #1;
        chk("one_valid", 32'(res_valid), 32'd1);
        chk("one_id", 32'(res_id), 32'(idx));
        chk("one_prod", 32'(res_prod), 32'(exp_prod));
        chk("one_ovf", 32'(res_overflow), 32'(exp_ovf));
        tick();
        #1;
        chk("one_drop", {res_valid, busy, res_prod}, {1'b0, 1'b0, exp_prod});
    endtask

    initial begin
        rst       = 1'b1;
        req       = 4'b0000;
        op_a      = '0;
        op_b      = '0;
        res_ready = 1'b0;
        tick();
        tick();
        #1;
        chk("rst_grant", 32'(grant), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_valid", 32'(res_valid), 32'd0);
        chk("rst_data", {res_id, res_prod, res_overflow}, 32'd0);
        req = 4'b1111;
        #1;
        chk("rst_forces_grant0", 32'(grant), 32'd0);
        req = 4'b0000;

        rst = 1'b0;
        for (int i = 0; i < 10; i++) begin
            #1;
            chk("idle_quiet", {grant, busy, res_valid}, 32'd0);
            tick();
        end

        // 3 * -2 = -6 -> 1010
        run_one(0, 4'd3, 4'b1110, 4'b0001, 4'b1010, 1'b0);
        // -6 * 2 = -12 -> 0100, overflow
        run_one(1, 4'b1010, 4'd2, 4'b0010, 4'b0100, 1'b1);
        // -8 * -1 = +8 -> 1000, overflow
        run_one(1, 4'b1000, 4'b1111, 4'b0010, 4'b1000, 1'b1);
        // -1 * -1 = 1 -> 0001
        run_one(1, 4'b1111, 4'b1111, 4'b0010, 4'b0001, 1'b0);

        // Reset clears rr_ptr before the fairness sweep.
        rst = 1'b1;
        tick();
        rst = 1'b0;

        // Lanes hold a=1..4, b=-1 -> products F,E,D,C.
        op_a      = {4'd4, 4'd3, 4'd2, 4'd1};
        op_b      = 16'hFFFF;
        req       = 4'b1111;
        res_ready = 1'b1;
        for (int g = 0; g < 5; g++) begin
            #1;
            chk("rr_grant", 32'(grant), 32'(4'b0001 << (g % 4)));
            tick();
            #1;
            chk("rr_gap1", 32'(grant), 32'd0);
            tick();
            #1;
            chk("rr_gap2", 32'(grant), 32'd0);
            chk("rr_id", 32'(res_id), 32'(g % 4));
            chk("rr_prod", 32'(res_prod), 32'(4'hF - 4'(g % 4)));
            tick();
        end

        // Backpressure: last grant was lane 0, so lane 1 is next.
        res_ready = 1'b0;
        #1;
        chk("bp_grant", 32'(grant), 32'b0010);
        tick();
        tick();
        for (int i = 0; i < 5; i++) begin
            #1;
            chk("bp_hold", {res_valid, busy, grant, res_id, res_prod, res_overflow},
                {1'b1, 1'b1, 4'b0000, 2'd1, 4'hE, 1'b0});
            tick();
        end
        res_ready = 1'b1;
        #1;
        chk("bp_ready_nogrant", {res_valid, grant}, {1'b1, 4'b0000});
        tick();
        #1;
        chk("bp_release", {res_valid, busy, grant}, {1'b0, 1'b0, 4'b0100});
        tick();
        req = 4'b0000;
        tick();
        tick();

        // Reset during MUL discards the operation; lane 3 is next in line.
        req = 4'b1111;
        #1;
        chk("mr_grant", 32'(grant), 32'b1000);
        tick();
        rst = 1'b1;
        req = 4'b0000;
        #1;
        chk("mr_in_mul", {busy, grant}, {1'b1, 4'b0000});
        tick();
        #1;
        chk("mr_after_rst", {res_valid, busy, grant}, 32'd0);
        tick();
        rst = 1'b0;
        #1;
        chk("mr_no_result", 32'(res_valid), 32'd0);
        req = 4'b1001;
        #1;
        chk("mr_ptr_reset", 32'(grant), 32'b0001);
        tick();
        req = 4'b0000;
        tick();
        #1;
        chk("mr_result", {res_valid, res_id, res_prod, res_overflow},
            {1'b1, 2'd0, 4'hF, 1'b0});
        tick();
        #1;
        chk("mr_done", 32'(res_valid), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
